// File: rtl/mem_bus_ctl.sv
// mem_bus_ctl: data-side bus sequencer sitting after the MMU.
// Faulting requests are bounced back as mmu_fault/trap. Clean requests run one
// external access with programmable wait states and byte lanes, then return
// the formatted load data.
module mem_bus_ctl #(
  parameter int RV          = 16,
  parameter int PA          = RV,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_write,
  input  logic          req_byte,
  input  logic          req_bhi,
  input  logic [RV-1:0] req_wdata,
  input  logic [PA-2:0] addrp,
  input  logic          mmu_miss_fault,
  input  logic          mmu_prot_fault,
  output logic          mmu_fault,
  output logic          trap,
  output logic          done,
  output logic [RV-1:0] rdata,
  output logic          bus_cs,
  output logic          bus_we,
  output logic [1:0]    bus_be,
  output logic [PA-2:0] bus_addr,
  output logic [RV-1:0] bus_wdata,
  input  logic [RV-1:0] bus_rdata,
  input  logic          bus_wait
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  be_q;
  logic        fault_in;
  logic        access_end;

  assign fault_in   = mmu_miss_fault | mmu_prot_fault;
  assign access_end = (wait_cnt == 4'd0) && !bus_wait;

  // The MMU samples this in the request cycle, so it must be combinational.
  assign mmu_fault = (state == IDLE) && req && fault_in;

  assign bus_cs = (state == ACCESS);
  assign bus_we = (state == ACCESS) && we_q;
  assign bus_be = (state == ACCESS) ? be_q : 2'b00;
  assign done   = (state == DONE);
  assign trap   = (state == FAULT);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; bus_wait only matters once the wait counter has expired.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = fault_in ? FAULT : ACCESS;
      ACCESS:  if (access_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      FAULT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latching, wait counting and load-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !fault_in) begin
            bus_addr  <= addrp;
            we_q      <= req_write;
            wait_cnt  <= 4'(WAIT_STATES);
            be_q      <= req_byte ? (req_bhi ? 2'b10 : 2'b01) : 2'b11;
            bus_wdata <= req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!bus_wait && !we_q) begin
            case (be_q)
              2'b01:   rdata <= {8'h00, bus_rdata[7:0]};
              2'b10:   rdata <= {8'h00, bus_rdata[15:8]};
              default: rdata <= bus_rdata;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
